// File: rtl/pipe_hazard_ctrl_if.sv
// Bus between the 5-stage datapath and the hazard controller: hazard inputs plus
// register enables, flushes, forwarding selects and the timeout flag.
interface pipe_hazard_ctrl_if;
  logic [4:0] rs1_id;
  logic [4:0] rs2_id;
  logic [4:0] rs1_ex;
  logic [4:0] rs2_ex;
  logic [4:0] rd_ex;
  logic       memread_ex;
  logic       branch_taken_ex;
  logic [4:0] rd_mem;
  logic       regwrite_mem;
  logic [4:0] rd_wb;
  logic       regwrite_wb;
  logic       dmem_req;
  logic       dmem_ready;

  logic       en_pc;
  logic       en_ifid;
  logic       en_idex;
  logic       en_exmem;
  logic       en_memwb;
  logic       flush_ifid;
  logic       flush_idex;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       mem_timeout;

  modport master (
    output rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, memread_ex, branch_taken_ex,
           rd_mem, regwrite_mem, rd_wb, regwrite_wb, dmem_req, dmem_ready,
    input  en_pc, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex,
           fwd_a, fwd_b, mem_timeout
  );

  modport slave (
    input  rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, memread_ex, branch_taken_ex,
           rd_mem, regwrite_mem, rd_wb, regwrite_wb, dmem_req, dmem_ready,
    output en_pc, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex,
           fwd_a, fwd_b, mem_timeout
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: stage enables/flushes, EX forwarding, dmem wait FSM with timeout.
// Optional perf counters (stall_cnt, flush_cnt, lu_cnt) when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT_CYC = 256
`ifdef HAZ_PERF_CNT_EN
  , parameter int CNT_W     = 32
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  pipe_hazard_ctrl_if.slave     hz
`ifdef HAZ_PERF_CNT_EN
  , output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [CNT_W-1:0]      lu_cnt
`endif
);

  localparam int WCW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t         state_q;
  logic [WCW-1:0] wait_cnt_q;
  logic           mem_timeout_q;

  logic mem_stall;
  logic load_use;
  logic frozen;

  assign mem_stall = hz.dmem_req && !hz.dmem_ready;
  assign load_use  = hz.memread_ex && (hz.rd_ex != 5'd0) &&
                     ((hz.rd_ex == hz.rs1_id) || (hz.rd_ex == hz.rs2_id));
  assign frozen    = (state_q == ST_ERR) || mem_stall;

  // Forwarding: one identical select per EX operand; MEM has the newer value so it wins.
  logic [4:0] rs_ex [2];
  logic [1:0] fwd   [2];

  assign rs_ex[0] = hz.rs1_ex;
  assign rs_ex[1] = hz.rs2_ex;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    assign fwd[gi] = reset ? 2'b00 :
                     (hz.regwrite_mem && (hz.rd_mem != 5'd0) && (hz.rd_mem == rs_ex[gi])) ? 2'b10 :
                     (hz.regwrite_wb  && (hz.rd_wb  != 5'd0) && (hz.rd_wb  == rs_ex[gi])) ? 2'b01 :
                     2'b00;
  end

  assign hz.fwd_a       = fwd[0];
  assign hz.fwd_b       = fwd[1];
  assign hz.mem_timeout = mem_timeout_q;

  always_comb begin
    hz.en_pc      = 1'b1;
    hz.en_ifid    = 1'b1;
    hz.en_idex    = 1'b1;
    hz.en_exmem   = 1'b1;
    hz.en_memwb   = 1'b1;
    hz.flush_ifid = 1'b0;
    hz.flush_idex = 1'b0;
    if (reset) begin
      hz.en_pc      = 1'b0;
      hz.en_ifid    = 1'b0;
      hz.en_idex    = 1'b0;
      hz.en_exmem   = 1'b0;
      hz.en_memwb   = 1'b0;
      hz.flush_ifid = 1'b1;
      hz.flush_idex = 1'b1;
    end else if (frozen) begin
      hz.en_pc    = 1'b0;
      hz.en_ifid  = 1'b0;
      hz.en_idex  = 1'b0;
      hz.en_exmem = 1'b0;
      hz.en_memwb = 1'b0;
    end else if (hz.branch_taken_ex) begin
      // A held branch reaches here only once the freeze lifts, so it flushes exactly once.
      hz.flush_ifid = 1'b1;
      hz.flush_idex = 1'b1;
    end else if (load_use) begin
      hz.en_pc      = 1'b0;
      hz.en_ifid    = 1'b0;
      hz.flush_idex = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mem_stall) begin
            state_q    <= ST_WAIT;
            wait_cnt_q <= WCW'(1);
          end
        end
        ST_WAIT: begin
          // Completion or a withdrawn request both end the wait.
          if (!hz.dmem_req || hz.dmem_ready) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_q       <= ST_ERR;
            mem_timeout_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + WCW'(1);
          end
        end
        ST_ERR: begin
          mem_timeout_q <= 1'b1;
        end
        default: begin
          state_q    <= ST_RUN;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] lu_cnt_q;
  logic             flush_fire;
  logic             lu_fire;

  assign flush_fire = !frozen && hz.branch_taken_ex;
  assign lu_fire    = !frozen && !hz.branch_taken_ex && load_use;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      lu_cnt_q    <= '0;
    end else begin
      if (mem_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_fire && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
      if (lu_fire && (lu_cnt_q != '1)) lu_cnt_q <= lu_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign lu_cnt    = lu_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, hand-written wait/timeout sequences and
// randomized cycles against a cycle-level behavioural model; counters checked with HAZ_PERF_CNT_EN.
module tb_pipe_hazard_ctrl;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus ();

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt, lu_cnt;
`endif

  pipe_hazard_ctrl #(
    .TIMEOUT_CYC(TMO)
`ifdef HAZ_PERF_CNT_EN
    , .CNT_W(32)
`endif
  ) dut (
    .clk(clk),
    .reset(rst),
    .hz(bus)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt),
    .lu_cnt(lu_cnt)
`endif
  );

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex;
    logic       mr, br;
    logic [4:0] rd_mem;
    logic       rwm;
    logic [4:0] rd_wb;
    logic       rww;
    logic       req, rdy;
  } in_t;

  typedef struct {
    in_t        in;
    logic [11:0] exp;
  } vec_t;

  int nchk = 0;
  int nerr = 0;

  // Reference model state: consecutive stalled cycles, error latch, counters.
  int          m_run = 0;
  bit          m_err = 0;
  bit          m_mto = 0;
  int unsigned m_stall = 0, m_flush = 0, m_lu = 0;

  function automatic in_t mk(input logic r, input logic [4:0] a, input logic [4:0] b,
                             input logic [4:0] c, input logic [4:0] d, input logic [4:0] e,
                             input logic mr, input logic br, input logic [4:0] rm, input logic rwm,
                             input logic [4:0] rw, input logic rww, input logic req, input logic rdy);
    in_t x;
    x.rst = r; x.rs1_id = a; x.rs2_id = b; x.rs1_ex = c; x.rs2_ex = d; x.rd_ex = e;
    x.mr = mr; x.br = br; x.rd_mem = rm; x.rwm = rwm; x.rd_wb = rw; x.rww = rww;
    x.req = req; x.rdy = rdy;
    return x;
  endfunction

  function automatic logic [11:0] ex(input logic [4:0] en, input logic [1:0] fl,
                                     input logic [1:0] fa, input logic [1:0] fb, input logic mto);
    return {en, fl, fa, fb, mto};
  endfunction

  function automatic logic [11:0] outv();
    return {bus.en_pc, bus.en_ifid, bus.en_idex, bus.en_exmem, bus.en_memwb,
            bus.flush_ifid, bus.flush_idex, bus.fwd_a, bus.fwd_b, bus.mem_timeout};
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] rs, input in_t x);
    if (x.rwm && x.rd_mem != 0 && x.rd_mem == rs) return 2'b10;
    if (x.rww && x.rd_wb != 0 && x.rd_wb == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [11:0] m_out(input in_t x);
    bit stall, lu;
    logic [1:0] fa, fb;
    if (x.rst) return ex(5'b00000, 2'b11, 2'b00, 2'b00, m_mto);
    fa = m_fwd(x.rs1_ex, x);
    fb = m_fwd(x.rs2_ex, x);
    stall = x.req && !x.rdy;
    lu = x.mr && x.rd_ex != 0 && (x.rd_ex == x.rs1_id || x.rd_ex == x.rs2_id);
    if (m_err || stall) return ex(5'b00000, 2'b00, fa, fb, m_mto);
    if (x.br)           return ex(5'b11111, 2'b11, fa, fb, m_mto);
    if (lu)             return ex(5'b00111, 2'b01, fa, fb, m_mto);
    return ex(5'b11111, 2'b00, fa, fb, m_mto);
  endfunction

  task automatic m_update(input in_t x);
    bit stall, lu;
    stall = x.req && !x.rdy;
    lu = x.mr && x.rd_ex != 0 && (x.rd_ex == x.rs1_id || x.rd_ex == x.rs2_id);
    if (x.rst) begin
      m_run = 0; m_err = 0; m_mto = 0;
      m_stall = 0; m_flush = 0; m_lu = 0;
    end else begin
      if (stall) m_stall++;
      if (!m_err && !stall && x.br) m_flush++;
      if (!m_err && !stall && !x.br && lu) m_lu++;
      if (!m_err) begin
        if (stall) begin
          m_run++;
          if (m_run >= TMO) begin m_err = 1; m_mto = 1; end
        end else begin
          m_run = 0;
        end
      end
    end
  endtask

  task automatic drive(input in_t x);
    rst = x.rst;
    bus.rs1_id = x.rs1_id; bus.rs2_id = x.rs2_id;
    bus.rs1_ex = x.rs1_ex; bus.rs2_ex = x.rs2_ex; bus.rd_ex = x.rd_ex;
    bus.memread_ex = x.mr; bus.branch_taken_ex = x.br;
    bus.rd_mem = x.rd_mem; bus.regwrite_mem = x.rwm;
    bus.rd_wb = x.rd_wb; bus.regwrite_wb = x.rww;
    bus.dmem_req = x.req; bus.dmem_ready = x.rdy;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end else begin
      $display("ok   %s val=%0h", nm, got);
    end
  endtask

  // One clock: drive after negedge, compare mid-low-phase, advance model on posedge.
  task automatic step(input in_t x, input logic [11:0] exp, input string nm);
    drive(x);
    #1;
    check(nm, 32'(outv()), 32'(exp));
    @(posedge clk);
    m_update(x);
    @(negedge clk);
  endtask

  task automatic step_nc(input in_t x);
    drive(x);
    @(posedge clk);
    m_update(x);
    @(negedge clk);
  endtask

  vec_t vt [13];
  in_t  I, S, R, RS, LU, BL, BR;
  localparam logic [11:0] FRZ0 = 12'b00000_00_00_00_0;
  localparam logic [11:0] FRZ1 = 12'b00000_00_00_00_1;
  localparam logic [11:0] NRM  = 12'b11111_00_00_00_0;
  localparam logic [11:0] RST0 = 12'b00000_11_00_00_0;
  localparam logic [11:0] RST1 = 12'b00000_11_00_00_1;

  initial begin
    I  = mk(0, 0,0,0,0,0, 0,0, 0,0, 0,0, 0,0);
    S  = mk(0, 0,0,0,0,0, 0,0, 0,0, 0,0, 1,0);
    R  = mk(0, 0,0,0,0,0, 0,0, 0,0, 0,0, 1,1);
    RS = mk(1, 0,0,0,0,0, 0,0, 0,0, 0,0, 0,0);
    LU = mk(0, 0,7,0,0,7, 1,0, 0,0, 0,0, 0,0);
    BL = mk(0, 0,7,0,0,7, 1,1, 0,0, 0,0, 0,0);
    BR = mk(0, 0,0,0,0,0, 0,1, 0,0, 0,0, 0,0);

    vt[0]  = '{mk(0, 0,0,5,0,0, 0,0, 5,1, 5,1, 0,0), ex(5'b11111, 2'b00, 2'b10, 2'b00, 0)};
    vt[1]  = '{mk(0, 0,0,0,0,0, 0,0, 0,1, 0,1, 0,0), ex(5'b11111, 2'b00, 2'b00, 2'b00, 0)};
    vt[2]  = '{mk(0, 0,0,4,3,0, 0,0, 4,1, 3,1, 0,0), ex(5'b11111, 2'b00, 2'b10, 2'b01, 0)};
    vt[3]  = '{mk(0, 0,0,6,6,0, 0,0, 6,0, 6,1, 0,0), ex(5'b11111, 2'b00, 2'b01, 2'b01, 0)};
    vt[4]  = '{mk(0, 9,0,0,0,9, 1,0, 0,0, 0,0, 0,0), ex(5'b00111, 2'b01, 2'b00, 2'b00, 0)};
    vt[5]  = '{mk(0, 0,0,0,0,0, 1,0, 0,0, 0,0, 0,0), ex(5'b11111, 2'b00, 2'b00, 2'b00, 0)};
    vt[6]  = '{mk(0, 9,0,0,0,9, 0,0, 0,0, 0,0, 0,0), ex(5'b11111, 2'b00, 2'b00, 2'b00, 0)};
    vt[7]  = '{mk(0, 9,9,0,0,9, 1,1, 0,0, 0,0, 0,0), ex(5'b11111, 2'b11, 2'b00, 2'b00, 0)};
    vt[8]  = '{mk(0, 0,0,0,0,0, 0,1, 0,0, 0,0, 0,0), ex(5'b11111, 2'b11, 2'b00, 2'b00, 0)};
    vt[9]  = '{mk(0, 0,0,2,0,0, 0,1, 2,1, 0,0, 1,0), ex(5'b00000, 2'b00, 2'b10, 2'b00, 0)};
    vt[10] = '{mk(0, 0,0,0,0,0, 0,0, 0,0, 0,0, 1,1), ex(5'b11111, 2'b00, 2'b00, 2'b00, 0)};
    vt[11] = '{mk(0, 0,0,0,0,0, 0,0, 0,0, 0,0, 0,1), ex(5'b11111, 2'b00, 2'b00, 2'b00, 0)};
    vt[12] = '{mk(1, 0,0,3,3,0, 1,1, 3,1, 3,1, 1,0), ex(5'b00000, 2'b11, 2'b00, 2'b00, 0)};

    drive(RS);
    @(negedge clk);
    step_nc(RS);
    step(RS, RST0, "reset_state");

    for (int i = 0; i < 13; i++) step(vt[i].in, vt[i].exp, $sformatf("vec%0d", i));

    // Load-use bubble lasts exactly one cycle; branch beats load-use.
    step(LU, ex(5'b00111, 2'b01, 0, 0, 0), "t2_lu");
    step(I, NRM, "t2_after");
    step(BL, ex(5'b11111, 2'b11, 0, 0, 0), "t3_br_lu");

    // Three wait cycles then ready; a following 7-cycle wait must not time out.
    for (int i = 0; i < 3; i++) step(S, FRZ0, $sformatf("t4_wait%0d", i));
    step(R, NRM, "t4_ready");
    for (int i = 0; i < TMO - 1; i++) step(S, FRZ0, $sformatf("t4_long%0d", i));
    step(R, NRM, "t4_long_ready");
    step(I, NRM, "t4_no_tmo");

    // Withdrawn request clears the wait count.
    for (int i = 0; i < 5; i++) step(S, FRZ0, $sformatf("wd_a%0d", i));
    step(I, NRM, "wd_drop");
    for (int i = 0; i < TMO - 1; i++) step(S, FRZ0, $sformatf("wd_b%0d", i));
    step(I, NRM, "wd_no_tmo");

    // Reset in the middle of a wait.
    for (int i = 0; i < 6; i++) step(S, FRZ0, $sformatf("rw_a%0d", i));
    step(RS, RST0, "rw_reset");
    for (int i = 0; i < TMO - 1; i++) step(S, FRZ0, $sformatf("rw_b%0d", i));
    step(R, NRM, "rw_ready");

    // Timeout: exactly TMO stalled cycles, then sticky freeze until reset.
    for (int i = 0; i < TMO; i++) step(S, FRZ0, $sformatf("t5_wait%0d", i));
    step(R, FRZ1, "t5_err_ready");
    step(BR, FRZ1, "t5_err_branch");
    step(I, FRZ1, "t5_err_idle");
    step(RS, RST1, "t5_reset");
    step(I, NRM, "t5_recovered");

    for (int k = 0; k < 400; k++) begin
      in_t x;
      int rdy_lim;
      rdy_lim = ((k / 100) % 2 == 1) ? 1 : 5;
      x.rst    = ($urandom_range(0, 39) == 0);
      x.rs1_id = 5'($urandom_range(0, 3)); x.rs2_id = 5'($urandom_range(0, 3));
      x.rs1_ex = 5'($urandom_range(0, 3)); x.rs2_ex = 5'($urandom_range(0, 3));
      x.rd_ex  = 5'($urandom_range(0, 3));
      x.mr     = 1'($urandom_range(0, 1)); x.br = ($urandom_range(0, 3) == 0);
      x.rd_mem = 5'($urandom_range(0, 3)); x.rwm = 1'($urandom_range(0, 1));
      x.rd_wb  = 5'($urandom_range(0, 3)); x.rww = 1'($urandom_range(0, 1));
      x.req    = ($urandom_range(0, 9) != 0);
      x.rdy    = ($urandom_range(0, 9) < rdy_lim);
      step(x, m_out(x), $sformatf("rnd%0d", k));
    end

`ifdef HAZ_PERF_CNT_EN
    check("rnd_stall_cnt", stall_cnt, m_stall);
    check("rnd_flush_cnt", flush_cnt, m_flush);
    check("rnd_lu_cnt", lu_cnt, m_lu);
    step(RS, m_out(RS), "t6_reset");
    check("t6_clear", stall_cnt | flush_cnt | lu_cnt, 0);
    step(LU, ex(5'b00111, 2'b01, 0, 0, 0), "t6_lu");
    step(I, NRM, "t6_idle");
    step(BL, ex(5'b11111, 2'b11, 0, 0, 0), "t6_br_lu");
    for (int i = 0; i < 3; i++) step(S, FRZ0, $sformatf("t6_wait%0d", i));
    step(R, NRM, "t6_ready");
    check("t6_lu_cnt", lu_cnt, 1);
    check("t6_flush_cnt", flush_cnt, 1);
    check("t6_stall_cnt", stall_cnt, 3);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
